// File: rtl/pmu_i2c_arbiter_if.sv
// pmu_i2c_arbiter_if: requester strobes and engine controls shared by the PMU I2C arbiter
interface pmu_i2c_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0] req, grant, req_start, req_done, req_rw;
  logic [NUM_REQ-1:0] req_data_latch, req_in_data_valid, req_failed, timeout;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0] eng_data;
  logic eng_start, eng_done, eng_rw, eng_clear_failed;
  logic eng_data_latch, eng_ready, eng_failed, eng_in_data_valid;
  modport master (
    output req, req_start, req_done, req_rw, req_data,
    output eng_data_latch, eng_ready, eng_failed, eng_in_data_valid,
    input grant, req_data_latch, req_in_data_valid, req_failed, timeout,
    input eng_data, eng_start, eng_done, eng_rw, eng_clear_failed
  );
  modport slave (
    input req, req_start, req_done, req_rw, req_data,
    input eng_data_latch, eng_ready, eng_failed, eng_in_data_valid,
    output grant, req_data_latch, req_in_data_valid, req_failed, timeout,
    output eng_data, eng_start, eng_done, eng_rw, eng_clear_failed
  );
endinterface

// File: rtl/pmu_i2c_arbiter.sv
// pmu_i2c_arbiter: round-robin sharing of one PMU I2C byte engine among NUM_REQ requesters
module pmu_i2c_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT_LOG2 = 16
) (
  input logic clk,
  input logic reset,
  pmu_i2c_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 2 ? 2 : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, GRANT, DRAIN, GAP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] winner, last, pick, idx;
  logic [NUM_REQ-1:0] grant_q, failed_q;
  logic [TIMEOUT_LOG2-1:0] wd;
  logic timed_out, expire, win_req;
  assign win_req = bus.req[winner];
  assign expire = state == GRANT && &wd && win_req;
  assign bus.grant = grant_q;
  assign bus.req_failed = failed_q;
  assign bus.timeout = expire ? grant_q : '0;
  // round-robin pick: first active requester after last, wrapping
  always_comb begin
    pick = last;
    idx = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_REQ);
      if (bus.req[idx]) pick = idx;
    end
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state and engine-side routing, inactive outside the grant window
  always_comb begin
    state_nx = state;
    bus.eng_start = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_rw = 1'b1;
    bus.eng_data = 8'h00;
    bus.eng_clear_failed = 1'b0;
    bus.req_data_latch = '0;
    bus.req_in_data_valid = '0;
    case (state)
      IDLE: state_nx = bus.eng_ready && |bus.req ? CLEAR : IDLE;
      CLEAR: begin
        bus.eng_clear_failed = 1'b1;
        state_nx = GRANT;
      end
      GRANT: begin
        bus.eng_start = bus.req_start[winner];
        bus.eng_done = bus.req_done[winner];
        bus.eng_rw = bus.req_rw[winner];
        bus.eng_data = bus.req_data[{winner, 3'b000} +: 8];
        bus.req_data_latch = bus.eng_data_latch ? grant_q : '0;
        bus.req_in_data_valid = bus.eng_in_data_valid ? grant_q : '0;
        state_nx = !win_req || &wd ? DRAIN : GRANT;
      end
      DRAIN: begin
        bus.eng_done = 1'b1;
        state_nx = bus.eng_ready ? GAP : DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end
  // ownership, watchdog and per-requester failure bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner <= '0;
      last <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      failed_q <= '0;
      wd <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (state_nx == CLEAR) begin
          winner <= pick;
          grant_q <= NUM_REQ'(1) << pick;
          wd <= '0;
          timed_out <= 1'b0;
        end
        CLEAR: failed_q[winner] <= 1'b0;
        GRANT: begin
          wd <= bus.eng_data_latch ? '0 : (&wd ? wd : wd + TIMEOUT_LOG2'(1));
          if (state_nx == DRAIN) grant_q <= '0;
          if (expire) timed_out <= 1'b1;
        end
        DRAIN: if (bus.eng_ready) begin
          failed_q[winner] <= bus.eng_failed | timed_out;
          last <= winner;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/pmu_i2c_arbiter.md
# pmu_i2c_arbiter

Shares one byte-level PMU I2C engine between up to four independent transaction sources, such as the rail-set path, the rail-query path and a periodic housekeeping poller. It sits between those requesters and the I2C engine, and grants the engine to one requester at a time in round-robin order. While a requester holds the grant, its start/done/rw/data strobes pass straight through to the engine. The block also clears and captures the engine's failure status per transaction, and forcibly reclaims the engine from a requester that stalls.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- TIMEOUT_LOG2, 16, watchdog width; a grant with no byte progress for 2^TIMEOUT_LOG2-1 cycles is revoked

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  level request; held for the whole transaction, dropped to release
- grant  out  NUM_REQ  one-hot (or zero) ownership indication
- req_start / req_done / req_rw  in  NUM_REQ each  per-requester engine strobes; rw=1 write, rw=0 read
- req_data  in  8*NUM_REQ  per-requester outgoing byte; requester i uses bits [8i+7:8i]
- req_data_latch  out  NUM_REQ  eng_data_latch routed to the granted requester only
- req_in_data_valid  out  NUM_REQ  eng_in_data_valid routed to the granted requester only; read data is taken directly from the engine's in_data bus
- req_failed  out  NUM_REQ  failure status of each requester's last transaction, held until that requester's next grant
- timeout  out  NUM_REQ  one-cycle pulse when that requester's grant is revoked by the watchdog
- eng_data  out  8  byte to engine
- eng_start / eng_done / eng_rw / eng_clear_failed  out  1 each  engine controls
- eng_data_latch / eng_ready / eng_failed / eng_in_data_valid  in  1 each  engine status

## Operation
- State machine states: IDLE, CLEAR, GRANT, DRAIN, GAP.
- IDLE:
  - when eng_ready=1 and any req bit is high, select a winner round-robin, searching from last+1 upward with wrap.
  - on that edge: register grant[winner]=1, clear the watchdog, go to CLEAR.
- CLEAR:
  - eng_clear_failed=1 for exactly one cycle; eng_start=0.
  - clear req_failed[winner].
  - go to GRANT.
- GRANT:
  - eng_start/done/rw/data follow the winner's inputs combinationally.
  - eng_data_latch goes to req_data_latch[winner]; eng_in_data_valid goes to req_in_data_valid[winner]; all other bits are 0.
  - the watchdog increments every cycle and clears on eng_data_latch.
  - req[winner]=0: go to DRAIN.
  - watchdog at all-ones with req[winner] still 1: pulse timeout[winner], go to DRAIN.
- DRAIN:
  - grant=0, eng_done=1, eng_start=0.
  - when eng_ready=1: req_failed[winner] is set to eng_failed OR (a timeout occurred); last=winner; go to GAP.
- GAP: one idle cycle for engine bus-free time, then IDLE.
- Outside GRANT:
  - eng_start=0, eng_rw=1, eng_data=8'h00.
  - eng_done=0, except in DRAIN.
  - req_data_latch=0 and req_in_data_valid=0.
- Engine strobes from non-granted requesters are ignored entirely.

## Timing
- Reset values (asynchronous):
  - state=IDLE, grant=0, last=NUM_REQ-1 (so requester 0 wins first).
  - watchdog=0, req_failed=0, timeout=0.
  - all eng_* outputs inactive as listed above.
- Minimum grant latency:
  - req sampled high at edge k with eng_ready=1 → grant high from edge k, state CLEAR.
  - pass-through begins at edge k+1.
- Release to next grant:
  - req drops at edge m → DRAIN.
  - earliest eng_ready → GAP at m+1, IDLE at m+2, next grant at m+3.
- Simultaneous events:
  - requests arriving together resolve strictly by round-robin order.
  - a req drop and watchdog expiry in the same cycle count as a normal release: no timeout pulse, no forced failure.
  - req dropping during CLEAR is seen in GRANT, which moves to DRAIN the next cycle.
  - requests arriving during DRAIN/GAP wait for IDLE.
- A requester must not assert req_start before it sees grant. Strobes presented early are not forwarded and are not buffered.
- Reset mid-transaction: every engine output goes inactive immediately. The engine is assumed to be reset by the same signal.
- Watchdog: saturating counter of width TIMEOUT_LOG2, never wraps.

## Test plan
- Single requester: req[0] rises with eng_ready=1 → grant=3'b001 next edge, eng_clear_failed one cycle, then eng_data mirrors req_data[7:0]=8'h68. Drop req → eng_done=1 until eng_ready, then grant path idle for exactly one GAP cycle.
- Round-robin: req=3'b111 held continuously, each requester releasing after one transaction → grant sequence 001, 010, 100, 001 with 3-cycle release-to-grant spacing.
- Routing isolation: requester 1 granted, requester 2 toggles req_start → eng_start follows requester 1 only; eng_data_latch pulses appear only on req_data_latch[1].
- Failure capture: eng_failed=1 at requester 0's DRAIN → req_failed[0]=1 from GAP. Requester 0's next grant → eng_clear_failed pulse and req_failed[0] back to 0.
- Watchdog: TIMEOUT_LOG2=4, requester 2 holds req with no data_latch → timeout[2] pulses 15 cycles after GRANT entry, eng_done asserted, req_failed[2]=1, and requester 0 is granted next.
- Async reset during GRANT: assert reset mid-cycle → grant=0, eng_start=0, eng_rw=1 without waiting for a clock edge. After release, requester 0 wins first.
